// File: rtl/pwm_cap_pkg.sv
// Shared types and constants for the PWM input-capture block.
package pwm_cap_pkg;

    localparam int PWM_CAP_DATA_WIDTH = 16;
    localparam int PWM_CAP_MIN_DIV    = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } pwm_cap_state_e;

    typedef struct packed {
        logic [PWM_CAP_DATA_WIDTH-1:0] high;
        logic [PWM_CAP_DATA_WIDTH-1:0] period;
    } pwm_cap_meas_t;

endpackage

// File: rtl/pwm_cap_in_sync.sv
// Synchronizes the asynchronous PWM pad input and derives single-cycle rise/fall strobes.
module pwm_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pwm_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   hist_q;
    logic                   hist_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pwm_i};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign lvl_o  = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of one PWM input in prescaled ticks and
// offers each completed rise-fall-rise cycle through a one-entry valid/ready register.
module pwm_capture
    import pwm_cap_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] pscr_i,
    input  logic                  pwm_i,
    output logic                  meas_valid_o,
    input  logic                  meas_ready_i,
    output logic [DATA_WIDTH-1:0] meas_high_o,
    output logic [DATA_WIDTH-1:0] meas_period_o,
    output logic                  ovf_o,
    output logic                  ovr_o
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] high;
        logic [DATA_WIDTH-1:0] period;
    } meas_t;

    localparam logic [DATA_WIDTH-1:0] CNT_MAX = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] MIN_DIV = DATA_WIDTH'(PWM_CAP_MIN_DIV);
    localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1);

    pwm_cap_state_e        state_q, state_d;
    logic [DATA_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] high_lat_q, high_lat_d;
    meas_t                 res_q, res_d;
    logic                  meas_valid_q, meas_valid_d;
    logic                  ovf_q, ovf_d;
    logic                  ovr_q, ovr_d;

    logic                  sync_lvl_unused_s;
    logic                  rise_s;
    logic                  fall_s;
    logic [DATA_WIDTH-1:0] div_s;
    logic                  tick_s;
    logic                  sat_s;
    logic                  counting_s;
    logic                  restart_s;
    logic                  push_s;

    pwm_in_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .pwm_i  (pwm_i),
        .lvl_o  (sync_lvl_unused_s),
        .rise_o (rise_s),
        .fall_o (fall_s)
    );

    // The rise cycle itself is prescaler phase 0, so restart values depend on whether div==1.
    always_comb begin
        div_s      = (pscr_i < MIN_DIV) ? MIN_DIV : pscr_i;
        tick_s     = (pre_cnt_q >= (div_s - ONE));
        sat_s      = (cnt_q == CNT_MAX);
        counting_s = ((state_q == HIGH) || (state_q == LOW)) && !sat_s;
        push_s     = en_i && (state_q == LOW) && rise_s && !sat_s;
        restart_s  = en_i && rise_s && ((state_q == ARM) || push_s);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            pre_cnt_q    <= '0;
            cnt_q        <= '0;
            high_lat_q   <= '0;
            res_q        <= '0;
            meas_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            cnt_q        <= cnt_d;
            high_lat_q   <= high_lat_d;
            res_q        <= res_d;
            meas_valid_q <= meas_valid_d;
            ovf_q        <= ovf_d;
            ovr_q        <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ARM;
                ARM:     state_d = rise_s ? HIGH : ARM;
                HIGH: begin
                    if (sat_s) begin
                        state_d = ARM;
                    end else if (fall_s) begin
                        state_d = LOW;
                    end else begin
                        state_d = HIGH;
                    end
                end
                LOW: begin
                    if (sat_s) begin
                        state_d = ARM;
                    end else if (rise_s) begin
                        state_d = HIGH;
                    end else begin
                        state_d = LOW;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        pre_cnt_d    = pre_cnt_q;
        cnt_d        = cnt_q;
        high_lat_d   = high_lat_q;
        res_d        = res_q;
        meas_valid_d = meas_valid_q;
        ovf_d        = ovf_q;
        ovr_d        = ovr_q;
        if (!en_i) begin
            pre_cnt_d    = '0;
            cnt_d        = '0;
            high_lat_d   = '0;
            res_d        = '0;
            meas_valid_d = 1'b0;
            ovf_d        = 1'b0;
            ovr_d        = 1'b0;
        end else begin
            if (restart_s) begin
                pre_cnt_d = (div_s == ONE) ? '0 : ONE;
                cnt_d     = (div_s == ONE) ? ONE : '0;
            end else if (counting_s) begin
                pre_cnt_d = tick_s ? '0 : (pre_cnt_q + ONE);
                cnt_d     = tick_s ? (cnt_q + ONE) : cnt_q;
            end else begin
                pre_cnt_d = '0;
                cnt_d     = '0;
            end

            if ((state_q == HIGH) && fall_s && !sat_s) begin
                high_lat_d = cnt_q;
            end else begin
                high_lat_d = high_lat_q;
            end

            if (((state_q == HIGH) || (state_q == LOW)) && sat_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end

            // A push coinciding with a handshake replaces the consumed entry without overrun.
            if (push_s) begin
                if (meas_valid_q && !meas_ready_i) begin
                    ovr_d = 1'b1;
                end else begin
                    res_d.high   = high_lat_q;
                    res_d.period = cnt_q;
                    meas_valid_d = 1'b1;
                end
            end else if (meas_valid_q && meas_ready_i) begin
                meas_valid_d = 1'b0;
            end else begin
                meas_valid_d = meas_valid_q;
            end
        end
    end

    assign meas_valid_o  = meas_valid_q;
    assign meas_high_o   = res_q.high;
    assign meas_period_o = res_q.period;
    assign ovf_o         = ovf_q;
    assign ovr_o         = ovr_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized and directed bench for pwm_capture against an arithmetic reference model.
module tb_pwm_capture;

    localparam int DW  = 16;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en, pwm, ready;
    logic [DW-1:0] pscr;
    logic          valid, ovf, ovr;
    logic [DW-1:0] mh, mp;

    logic          en8, pwm8, ready8, valid8, ovf8, ovr8;
    logic [7:0]    pscr8, mh8, mp8;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            rdy_gap  = 0;
    bit            mon_on   = 1'b0;
    logic [31:0]   exp_q[$];
    logic [31:0]   got_q[$];

    pwm_capture #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .pscr_i(pscr), .pwm_i(pwm),
        .meas_valid_o(valid), .meas_ready_i(ready), .meas_high_o(mh),
        .meas_period_o(mp), .ovf_o(ovf), .ovr_o(ovr)
    );

    pwm_capture #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .clk_i(clk), .rst_i(rst), .en_i(en8), .pscr_i(pscr8), .pwm_i(pwm8),
        .meas_valid_o(valid8), .meas_ready_i(ready8), .meas_high_o(mh8),
        .meas_period_o(mp8), .ovf_o(ovf8), .ovr_o(ovr8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Ready is random but forced high at least once every 8 cycles.
    task automatic drive(input bit lvl, input int n);
        pwm = lvl;
        repeat (n) begin
            ready   = (rdy_gap >= 7) ? 1'b1 : 1'($urandom_range(0, 1));
            rdy_gap = ready ? 0 : rdy_gap + 1;
            tick(1);
        end
    endtask

    function automatic logic [31:0] model(input int h, input int l, input int ps);
        int div, hi, per;
        div = (ps < 1) ? 1 : ps;
        hi  = h / div;
        per = (h + l) / div;
        return {hi[15:0], per[15:0]};
    endfunction

    always @(negedge clk) begin
        if (mon_on && valid && ready) got_q.push_back({mh, mp});
    end

    task automatic run_scenario(input string tag, input int ps, input bit start_high,
                                input int ncyc, input int fh, input int fl);
        int h, l;
        en = 1'b0; pscr = ps[DW-1:0]; pwm = start_high; ready = 1'b1;
        tick(6);
        exp_q.delete(); got_q.delete(); rdy_gap = 0; mon_on = 1'b1;
        en = 1'b1;
        drive(start_high, 5 + $urandom_range(0, 20));
        if (start_high) drive(1'b0, 5 + $urandom_range(0, 20));
        for (int i = 0; i < ncyc; i++) begin
            h = (fh != 0) ? fh : $urandom_range(1, 60);
            l = (fl != 0) ? fl : $urandom_range((h >= 11) ? 1 : 12 - h, 80);
            drive(1'b1, h);
            drive(1'b0, l);
            exp_q.push_back(model(h, l, ps));
        end
        drive(1'b1, 10);
        ready = 1'b1;
        tick(10);
        mon_on = 1'b0;
        chk({tag, " count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s res%0d", tag, i), got_q[i], exp_q[i]);
        chk({tag, " ovr"}, ovr, 1'b0);
        chk({tag, " ovf"}, ovf, 1'b0);
        en = 1'b0; pwm = 1'b0;
        tick(3);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; pwm = 1'b0; ready = 1'b0; pscr = '0;
        en8 = 1'b0; pwm8 = 1'b0; ready8 = 1'b0; pscr8 = 8'd1;
        tick(3);
        chk("reset", {valid, ovf, ovr, mh, mp}, '0);
        chk("reset8", {valid8, ovf8, ovr8, mh8, mp8}, '0);
        rst = 1'b0;

        run_scenario("d1_30_70", 1, 1'b1, 4, 30, 70);
        run_scenario("d2_div4", 4, 1'b0, 3, 40, 60);
        run_scenario("d2_div0", 0, 1'b1, 3, 30, 70);
        for (int s = 0; s < 6; s++)
            run_scenario($sformatf("rnd%0d", s), $urandom_range(0, 6), 1'($urandom_range(0, 1)), 6, 0, 0);

        // Overrun: consumer stalled across three completed periods.
        en = 1'b0; pscr = 16'd1; pwm = 1'b0; ready = 1'b0; tick(5);
        en = 1'b1; tick(5);
        pwm = 1'b1; tick(20); pwm = 1'b0; tick(80);
        pwm = 1'b1; tick(25); pwm = 1'b0; tick(75);
        pwm = 1'b1; tick(35); pwm = 1'b0; tick(65);
        pwm = 1'b1; tick(5);
        chk("ovr held", {valid, ovr, mh, mp}, {1'b1, 1'b1, 16'd20, 16'd100});
        ready = 1'b1; tick(1); ready = 1'b0;
        chk("ovr drained", valid, 1'b0);
        tick(34); pwm = 1'b0; tick(60);
        chk("no stale", valid, 1'b0);
        pwm = 1'b1; tick(LAT);
        chk("fresh", {valid, ovr, mh, mp}, {1'b1, 1'b1, 16'd40, 16'd100});

        // Disable mid-HIGH, then re-arm.
        tick(5); en = 1'b0; tick(1);
        chk("en clear", {valid, ovf, ovr}, 3'b000);
        en = 1'b1; tick(5);
        pwm = 1'b0; tick(30); pwm = 1'b1; tick(10); pwm = 1'b0; tick(20);
        chk("rearm partial", valid, 1'b0);
        pwm = 1'b1; tick(LAT);
        chk("rearm res", {valid, mh, mp}, {1'b1, 16'd10, 16'd30});

        // Reset mid-LOW.
        pwm = 1'b0; tick(5); rst = 1'b1; tick(1);
        chk("rst midlow", {valid, ovf, ovr, mh, mp}, '0);
        rst = 1'b0;

        // Push coincident with handshake.
        ready = 1'b0; tick(5);
        pwm = 1'b1; tick(15); pwm = 1'b0; tick(35);
        pwm = 1'b1; tick(25);
        chk("coinc first", {valid, mh, mp}, {1'b1, 16'd15, 16'd50});
        pwm = 1'b0; tick(75);
        pwm = 1'b1; tick(LAT - 1);
        ready = 1'b1;
        chk("coinc before", {valid, mh, mp}, {1'b1, 16'd15, 16'd50});
        tick(1); ready = 1'b0;
        chk("coinc after", {valid, ovr, mh, mp}, {1'b1, 1'b0, 16'd25, 16'd100});

        // 8-bit instance: stuck-high input saturates the counter.
        en8 = 1'b1; tick(5);
        pwm8 = 1'b1; tick(250);
        chk("ovf8 early", ovf8, 1'b0);
        tick(50);
        chk("ovf8 set", {ovf8, valid8}, 2'b10);
        pwm8 = 1'b0; tick(20); pwm8 = 1'b1; tick(10); pwm8 = 1'b0; tick(20);
        chk("ovf8 nores", valid8, 1'b0);
        pwm8 = 1'b1; tick(LAT);
        chk("ovf8 res", {valid8, mh8, mp8}, {1'b1, 8'd10, 8'd30});
        chk("ovf8 sticky", ovf8, 1'b1);
        en8 = 1'b0; tick(1);
        chk("ovf8 clear", {ovf8, valid8}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
